// File: rtl/col_seq_ctrl_if.sv
// ============================================================================
// Module : col_seq_ctrl_if
// Brief  : Command handshake and column-decoder bus of the column sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface col_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [7:0] cmd_key;
    logic [2:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       MAC_en;
    logic [2:0] addr;
    logic [7:0] data;
    logic       pch_en;
    logic       sense_en;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_addr, cmd_len,
        input  cmd_ready, MAC_en, addr, data, pch_en, sense_en, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_addr, cmd_len,
        output cmd_ready, MAC_en, addr, data, pch_en, sense_en, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/col_seq_ctrl.sv
// ============================================================================
// Module : col_seq_ctrl
// Brief  : Column access sequencer (precharge/drive/evaluate) for MAC sweeps
//          and single-column CAM searches. Define COL_SEQ_ABORT_EN for abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module col_seq_ctrl #(
    parameter int PCH_CYC  = 2,
    parameter int EVAL_CYC = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef COL_SEQ_ABORT_EN
    input  wire logic        abort,
`endif
    col_seq_ctrl_if.slave    bus
);

    localparam logic [3:0] c_pch_load  = 4'(PCH_CYC - 1);
    localparam logic [3:0] c_eval_load = 4'(EVAL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PCH   = 3'd1,
        S_DRIVE = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_cols_left;
    logic       r_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_mac_en;
    logic [2:0] r_addr;
    logic [7:0] r_data;
    logic       r_pch_en;
    logic       r_sense_en;

    logic       w_accept;
    logic       w_abort;

    assign w_accept = bus.cmd_valid & r_ready;

`ifdef COL_SEQ_ABORT_EN
    assign w_abort = abort & ((r_state == S_PCH) | (r_state == S_DRIVE) | (r_state == S_EVAL));
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cols_left <= 3'd0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mac_en    <= 1'b0;
            r_addr      <= 3'd0;
            r_data      <= 8'd0;
            r_pch_en    <= 1'b0;
            r_sense_en  <= 1'b0;
        end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cols_left <= 3'd0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mac_en    <= 1'b0;
            r_addr      <= 3'd0;
            r_data      <= 8'd0;
            r_pch_en    <= 1'b0;
            r_sense_en  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        // Decoder drive is latched here and held for the whole access.
                        r_state     <= S_PCH;
                        r_ready     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pch_en    <= 1'b1;
                        r_cnt       <= c_pch_load;
                        r_mac_en    <= bus.cmd_op;
                        r_addr      <= bus.cmd_op ? bus.cmd_addr : 3'd0;
                        r_data      <= bus.cmd_op ? 8'd0 : bus.cmd_key;
                        r_cols_left <= bus.cmd_op ? bus.cmd_len : 3'd0;
                    end
                end
                S_PCH: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_DRIVE;
                        r_pch_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DRIVE: begin
                    r_state    <= S_EVAL;
                    r_sense_en <= 1'b1;
                    r_cnt      <= c_eval_load;
                end
                S_EVAL: begin
                    if (r_cnt == 4'd0) begin
                        r_sense_en <= 1'b0;
                        if (r_cols_left != 3'd0) begin
                            // Next column; the 3-bit address wraps 7 -> 0.
                            r_state     <= S_PCH;
                            r_cols_left <= r_cols_left - 3'd1;
                            r_addr      <= r_addr + 3'd1;
                            r_pch_en    <= 1'b1;
                            r_cnt       <= c_pch_load;
                        end else begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_mac_en <= 1'b0;
                            r_addr   <= 3'd0;
                            r_data   <= 8'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.MAC_en    = r_mac_en;
    assign bus.addr      = r_addr;
    assign bus.data      = r_data;
    assign bus.pch_en    = r_pch_en;
    assign bus.sense_en  = r_sense_en;

endmodule

`default_nettype wire

// File: tb/tb_col_seq_ctrl.sv
// ============================================================================
// Module : tb_col_seq_ctrl
// Brief  : Self-checking bench for col_seq_ctrl (default and 3/2 timing).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_col_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       c_valid0, c_valid1;
    logic       c_op;
    logic [7:0] c_key;
    logic [2:0] c_addr;
    logic [2:0] c_len;
    logic       c_abort;
    int         n_tests;
    int         n_fail;

    col_seq_ctrl_if bus0 ();
    col_seq_ctrl_if bus1 ();

    assign bus0.cmd_valid = c_valid0;
    assign bus0.cmd_op    = c_op;
    assign bus0.cmd_key   = c_key;
    assign bus0.cmd_addr  = c_addr;
    assign bus0.cmd_len   = c_len;
    assign bus1.cmd_valid = c_valid1;
    assign bus1.cmd_op    = c_op;
    assign bus1.cmd_key   = c_key;
    assign bus1.cmd_addr  = c_addr;
    assign bus1.cmd_len   = c_len;

`ifdef COL_SEQ_ABORT_EN
    col_seq_ctrl #(.PCH_CYC(2), .EVAL_CYC(1)) u_dut0 (.clk(clk), .rst(rst), .abort(c_abort), .bus(bus0));
    col_seq_ctrl #(.PCH_CYC(3), .EVAL_CYC(2)) u_dut1 (.clk(clk), .rst(rst), .abort(1'b0), .bus(bus1));
`else
    col_seq_ctrl #(.PCH_CYC(2), .EVAL_CYC(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    col_seq_ctrl #(.PCH_CYC(3), .EVAL_CYC(2)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
`endif

    // Observation vector: {MAC_en, addr, data, pch_en, sense_en, done, busy, cmd_ready}
    logic [16:0] w_obs0, w_obs1;
    assign w_obs0 = {bus0.MAC_en, bus0.addr, bus0.data, bus0.pch_en, bus0.sense_en,
                     bus0.done, bus0.busy, bus0.cmd_ready};
    assign w_obs1 = {bus1.MAC_en, bus1.addr, bus1.data, bus1.pch_en, bus1.sense_en,
                     bus1.done, bus1.busy, bus1.cmd_ready};

    localparam logic [16:0] c_idle  = 17'h00001;
    localparam logic [16:0] c_reset = 17'h00000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] obs(input int sel);
        return (sel != 0) ? w_obs1 : w_obs0;
    endfunction

    task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
    endtask

    // Expected per-cycle outputs, cycle 1 after the accept edge first.
    task automatic build_expected(input logic op, input logic [7:0] key, input logic [2:0] a,
                                  input logic [2:0] len, input int pc, input int ec,
                                  output logic [16:0] q[$]);
        int          n;
        logic [11:0] base;
        logic [2:0]  col;
        q.delete();
        n = op ? int'(len) + 1 : 1;
        for (int j = 0; j < n; j++) begin
            col  = op ? 3'((int'(a) + j) % 8) : 3'd0;
            base = {op, col, (op ? 8'h00 : key)};
            for (int k = 0; k < pc; k++) q.push_back({base, 5'b10010});
            q.push_back({base, 5'b00010});
            for (int k = 0; k < ec; k++) q.push_back({base, 5'b01010});
        end
        q.push_back({12'h000, 5'b00110});
    endtask

    // Called at a negedge with the target idle; returns at a negedge.
    // stop_after > 0 returns mid-command right after checking that cycle.
    task automatic run_cmd(input int sel, input logic op, input logic [7:0] key,
                           input logic [2:0] a, input logic [2:0] len, input bit hold,
                           input int stop_after, input string tag);
        logic [16:0] q[$];
        int          lim;
        build_expected(op, key, a, len, (sel != 0) ? 3 : 2, (sel != 0) ? 2 : 1, q);
        check({tag, ":pre"}, obs(sel), c_idle);
        c_op = op; c_key = key; c_addr = a; c_len = len;
        if (sel != 0) c_valid1 = 1'b1; else c_valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lim = (stop_after > 0) ? stop_after : q.size();
        for (int i = 0; i < lim; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                if (!hold) begin
                    c_valid0 = 1'b0;
                    c_valid1 = 1'b0;
                end
                // Fresh bus contents must not leak into the running command.
                c_op = 1'($urandom); c_key = 8'($urandom);
                c_addr = 3'($urandom); c_len = 3'($urandom);
            end
            check($sformatf("%s:cyc%0d", tag, i + 1), obs(sel), q[i]);
        end
        if (stop_after == 0) begin
            @(negedge clk);
            if (!hold) check({tag, ":post"}, obs(sel), c_idle);
        end
    endtask

    initial begin
        logic       r_op;
        logic [7:0] r_key;
        logic [2:0] r_a, r_len;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        c_valid0 = 1'b0;
        c_valid1 = 1'b0;
        c_op     = 1'b0;
        c_key    = 8'h00;
        c_addr   = 3'd0;
        c_len    = 3'd0;
        c_abort  = 1'b0;

        repeat (2) @(negedge clk);
        check("reset0", w_obs0, c_reset);
        check("reset1", w_obs1, c_reset);
        rst = 1'b0;
        @(negedge clk);
        check("idle0_after_reset", w_obs0, c_idle);
        check("idle1_after_reset", w_obs1, c_idle);

        run_cmd(0, 1'b0, 8'hAA, 3'd0, 3'd0, 1'b0, 0, "cam_aa");

        // Valid held high through a wrapping MAC; next command accepted right after DONE.
        run_cmd(0, 1'b1, 8'h00, 3'd6, 3'd3, 1'b1, 0, "mac_wrap_hold");
        run_cmd(0, 1'b1, 8'h5C, 3'd2, 3'd1, 1'b0, 0, "back_to_back");

        for (int t = 0; t < 10; t++) begin
            r_op  = 1'($urandom);
            r_key = 8'($urandom);
            r_a   = 3'($urandom);
            r_len = 3'($urandom);
            run_cmd(0, r_op, r_key, r_a, r_len, 1'b0, 0, $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check($sformatf("rand%0d:gap", t), w_obs0, c_idle);
            end
        end

        // Reset in the second column's EVAL (cycle 8 at default timing).
        run_cmd(0, 1'b1, 8'h00, 3'd5, 3'd2, 1'b0, 8, "mac_rst");
        rst = 1'b1;
        #1;
        check("rst_async", w_obs0, c_reset);
        @(negedge clk);
        check("rst_held", w_obs0, c_reset);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release", w_obs0, c_idle);
        run_cmd(0, 1'b1, 8'h00, 3'd1, 3'd1, 1'b0, 0, "after_rst");

        run_cmd(1, 1'b0, 8'h3C, 3'd0, 3'd0, 1'b0, 0, "cam_p3e2");
        run_cmd(1, 1'b1, 8'h00, 3'd7, 3'd1, 1'b0, 0, "mac_p3e2");

`ifdef COL_SEQ_ABORT_EN
        run_cmd(0, 1'b1, 8'h00, 3'd3, 3'd2, 1'b0, 3, "abort_drive");
        c_abort = 1'b1;
        @(negedge clk);
        c_abort = 1'b0;
        check("abort_idle", w_obs0, c_idle);
        @(negedge clk);
        check("abort_no_done", w_obs0, c_idle);
        c_abort = 1'b1;
        @(negedge clk);
        c_abort = 1'b0;
        check("abort_in_idle", w_obs0, c_idle);
        run_cmd(0, 1'b0, 8'h81, 3'd0, 3'd0, 1'b0, 0, "after_abort");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/col_seq_ctrl.md
COL_SEQ_CTRL -- requirements
Module: col_seq_ctrl

Interface
REQ-001 Parameter: PCH_CYC, 2, precharge cycles per column access; legal range 1..15.
REQ-002 Parameter: EVAL_CYC, 1, evaluate/sense cycles per column access; legal range 1..15.
REQ-003 Clock and reset: one clock, clk; reset rst, asynchronous, active-high.
REQ-004 Port: clk  in  1  sole clock, rising-edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: cmd_valid  in  1  command request.
REQ-007 Port: cmd_ready  out  1  high only in IDLE.
REQ-008 Port: cmd_op  in  1  operation select: 1 = MAC column sweep, 0 = CAM search.
REQ-009 Port: cmd_key  in  8  CAM search key; ignored for MAC.
REQ-010 Port: cmd_addr  in  3  MAC start column.
REQ-011 Port: cmd_len  in  3  MAC column count minus 1; ignored for CAM.
REQ-012 Port: MAC_en  out  1  column-decoder mode select.
REQ-013 Port: addr  out  3  column-decoder address.
REQ-014 Port: data  out  8  column-decoder key/data.
REQ-015 Port: pch_en  out  1  bitline precharge enable.
REQ-016 Port: sense_en  out  1  sense-amp evaluate strobe.
REQ-017 Port: busy  out  1  high in any state other than IDLE.
REQ-018 Port: done  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be: IDLE, PCH, DRIVE, EVAL, DONE; transitions occur on the clk rising edge.
REQ-020 Accept SHALL occur on a clk edge with cmd_valid and cmd_ready both high; on accept, cmd_op/cmd_key/cmd_addr/cmd_len are registered and the FSM enters PCH.
REQ-021 cmd_valid SHALL be ignored outside IDLE; no queuing; a new command is accepted no earlier than the cycle after DONE.
REQ-022 PCH SHALL last exactly PCH_CYC cycles with pch_en=1, then the FSM enters DRIVE.
REQ-023 DRIVE SHALL last exactly 1 cycle with pch_en=0 and sense_en=0, then the FSM enters EVAL.
REQ-024 EVAL SHALL last exactly EVAL_CYC cycles with sense_en=1.
REQ-025 MAC command: MAC_en=1, data=8'h00, addr=current column from PCH entry through the last EVAL cycle.
REQ-026 CAM command: MAC_en=0, addr=3'b000, data=registered key from PCH entry through the last EVAL cycle.
REQ-027 Column sequencing: at EVAL exit, if columns remain (MAC only), addr SHALL increment modulo 8 (7 wraps to 0) and the FSM re-enters PCH; otherwise it enters DONE.
REQ-028 addr/data/MAC_en SHALL change only on PCH entry, never within a column access.
REQ-029 CAM SHALL be exactly one column access.
REQ-030 MAC SHALL perform cmd_len+1 accesses.
REQ-031 DONE SHALL last 1 cycle with done=1 and all array controls at reset values, then the FSM enters IDLE.
REQ-032 Latency: done SHALL be high in cycle N*(PCH_CYC+1+EVAL_CYC)+1 after the accept edge, where N is the number of column accesses (defaults: CAM = 5).
REQ-033 In IDLE, MAC_en, addr, data, pch_en, sense_en and done SHALL all be 0.

Reset
REQ-034 Asserting rst SHALL immediately force IDLE; MAC_en=0, addr=0, data=0, pch_en=0, sense_en=0, done=0, busy=0, cmd_ready=0.
REQ-035 Reset mid-command SHALL discard that command with no done pulse; cmd_ready=1 from the first edge after rst deasserts.

Configuration
REQ-036 Macro COL_SEQ_ABORT_EN defined: adds input abort (1 bit); abort high in PCH/DRIVE/EVAL forces IDLE at the next edge with all outputs at IDLE values and no done pulse; abort is ignored in IDLE and DONE.
REQ-037 Macro COL_SEQ_ABORT_EN undefined: no abort port exists and every accepted command runs to DONE.

Verification
REQ-038 Reset, then CAM: cmd_op=0, key=8'hAA -> MAC_en=0, addr=0, data=AA for cycles 1-4; pch_en in cycles 1-2; sense_en in cycle 4; done in cycle 5.
REQ-039 MAC: addr=6, len=3 -> addr sequence 6,7,0,1 (wrap); MAC_en=1; data=0; done in cycle 17.
REQ-040 cmd_valid held high throughout a MAC command -> no second accept until IDLE; back-to-back accept occurs the cycle after DONE.
REQ-041 rst pulse during the second column's EVAL -> all outputs 0 immediately, no done pulse; a subsequent command behaves normally.
REQ-042 PCH_CYC=3, EVAL_CYC=2, CAM command -> done in cycle 7.
REQ-043 COL_SEQ_ABORT_EN defined, abort in DRIVE -> IDLE next edge, done never asserted, cmd_ready=1.
